// File: rtl/prefetch_port_arbiter_pkg.sv
// Shared types for the prefetch port arbiter: dcache port structs, the prefetch address type,
// the cacheable-region configuration and the arbitration FSM state encoding.
package prefetch_port_arbiter_pkg;

    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 44;
    localparam int unsigned PfAddrWidth        = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;
    localparam int unsigned MaxCachedRegions   = 2;

    typedef logic [PfAddrWidth-1:0] pf_addr_t;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [63:0]                   data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;

    typedef struct packed {
        logic [31:0]                        NrCachedRegionRules;
        logic [MaxCachedRegions-1:0][63:0]  CachedRegionAddrBase;
        logic [MaxCachedRegions-1:0][63:0]  CachedRegionLength;
    } pf_cfg_t;

    localparam pf_cfg_t ArianeDefaultConfig = '{
        NrCachedRegionRules:  32'd2,
        CachedRegionAddrBase: {64'h0000_0000_8000_0000, 64'h0000_0000_0000_0000},
        CachedRegionLength:   {64'h0000_0000_4000_0000, 64'h0000_0000_1000_0000}
    };

    typedef enum logic [1:0] {PfIdle, PfReq, PfTag} pf_state_e;

    function automatic logic is_cacheable(pf_cfg_t cfg, pf_addr_t addr);
        logic [63:0] a;
        a = 64'(addr);
        is_cacheable = 1'b0;
        for (int unsigned i = 0; i < MaxCachedRegions; i++) begin
            if (i < cfg.NrCachedRegionRules && a >= cfg.CachedRegionAddrBase[i] &&
                a < cfg.CachedRegionAddrBase[i] + cfg.CachedRegionLength[i]) begin
                is_cacheable = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/pf_addr_fifo.sv
// Small prefetch address FIFO; exposes every slot plus a valid mask so the
// push filter can reject addresses that are already queued.
module pf_addr_fifo
    import prefetch_port_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  pf_addr_t               wdata_i,
    output pf_addr_t               head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output pf_addr_t [Depth-1:0]   entries_o,
    output logic [Depth-1:0]       entry_vld_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    pf_addr_t [Depth-1:0] mem_q;

    assign head_o    = mem_q[rd_ptr_q];
    assign full_o    = (count_q == CntW'(Depth));
    assign empty_o   = (count_q == '0);
    assign entries_o = mem_q;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    // A slot is live when its distance from the read pointer is below the fill count.
    always_comb begin
        entry_vld_o = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            entry_vld_o[i] = ({1'b0, PtrW'(i) - rd_ptr_q} < count_q);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '0;
        end else begin
            count_q <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

endmodule

// File: rtl/prefetch_port_arbiter.sv
// Shares the dcache load port between CPU loads and queued prefetches. The CPU has priority;
// a granted prefetch always runs to completion and its read data is dropped.
module prefetch_port_arbiter
    import prefetch_port_arbiter_pkg::*;
#(
    parameter pf_cfg_t     ArianeCfg = ArianeDefaultConfig,
    parameter int unsigned PfDepth   = 4
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  dcache_req_i_t cpu_port_i,
    output dcache_req_o_t cpu_port_o,
    output dcache_req_i_t cache_port_o,
    input  dcache_req_o_t cache_port_i,
    input  logic          pf_valid_i,
    input  pf_addr_t      pf_addr_i,
    output logic          pf_ready_o,
    input  logic          pf_enable_i,
    output logic [31:0]   pf_issued_o,
    output logic [31:0]   pf_dropped_o
);

    pf_state_e              state_q, state_d;
    logic [1:0]             cpu_cnt_q, cpu_cnt_d;
    logic [31:0]            issued_q, dropped_q;
    pf_addr_t               issued_addr_q;
    logic                   issued_vld_q;
    pf_addr_t               head;
    logic                   fifo_full, fifo_empty;
    pf_addr_t [PfDepth-1:0] entries;
    logic [PfDepth-1:0]     entry_vld;
    logic                   push, pop, dup_hit, last_hit, cpu_quiet, cnt_inc, cnt_dec;

    pf_addr_fifo #(
        .Depth(PfDepth)
    ) u_fifo (
        .clk        (clk),
        .rst_ni     (rst_ni),
        .push_i     (push),
        .pop_i      (pop),
        .wdata_i    (pf_addr_i),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .entries_o  (entries),
        .entry_vld_o(entry_vld)
    );

    always_comb begin
        dup_hit = 1'b0;
        for (int unsigned i = 0; i < PfDepth; i++) begin
            if (entry_vld[i] && entries[i] == pf_addr_i) begin
                dup_hit = 1'b1;
            end
        end
    end

    assign last_hit = issued_vld_q && (issued_addr_q == pf_addr_i);
    assign pop      = (state_q == PfReq) && cache_port_i.data_gnt;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = pf_valid_i && is_cacheable(ArianeCfg, pf_addr_i) && !dup_hit && !last_hit &&
                      (!fifo_full || pop);

    assign pf_ready_o   = !fifo_full;
    assign pf_issued_o  = issued_q;
    assign pf_dropped_o = dropped_q;

    assign cnt_inc   = (state_q == PfIdle) && cpu_port_i.data_req && cache_port_i.data_gnt;
    assign cnt_dec   = ((state_q == PfIdle) && cache_port_i.data_rvalid) || cpu_port_i.kill_req;
    assign cpu_quiet = !cpu_port_i.data_req && !cpu_port_i.tag_valid && (cpu_cnt_q == 2'd0);

    always_comb begin
        cpu_cnt_d = cpu_cnt_q;
        if (cnt_inc && !cnt_dec && cpu_cnt_q != 2'd3) begin
            cpu_cnt_d = cpu_cnt_q + 2'd1;
        end else if (cnt_dec && !cnt_inc && cpu_cnt_q != 2'd0) begin
            cpu_cnt_d = cpu_cnt_q - 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PfIdle: if (pf_enable_i && !fifo_empty && cpu_quiet) state_d = PfReq;
            PfReq: begin
                if (cache_port_i.data_gnt) begin
                    state_d = PfTag;
                end else if (cpu_port_i.data_req) begin
                    state_d = PfIdle;
                end
            end
            PfTag:   if (cache_port_i.data_rvalid) state_d = PfIdle;
            default: state_d = PfIdle;
        endcase
    end

    always_comb begin
        cache_port_o = cpu_port_i;
        case (state_q)
            PfReq: begin
                cache_port_o               = '0;
                cache_port_o.address_index = head[DCACHE_INDEX_WIDTH-1:0];
                cache_port_o.address_tag   = head[PfAddrWidth-1:DCACHE_INDEX_WIDTH];
                cache_port_o.data_req      = 1'b1;
                cache_port_o.data_be       = 8'hFF;
                cache_port_o.data_size     = 2'd3;
            end
            PfTag: begin
                cache_port_o               = '0;
                cache_port_o.address_index = issued_addr_q[DCACHE_INDEX_WIDTH-1:0];
                cache_port_o.address_tag   = issued_addr_q[PfAddrWidth-1:DCACHE_INDEX_WIDTH];
                cache_port_o.tag_valid     = 1'b1;
            end
            default: ;
        endcase
    end

    // While a prefetch owns the port the CPU sees neither grants nor read data.
    always_comb begin
        cpu_port_o = cache_port_i;
        if (state_q != PfIdle) begin
            cpu_port_o.data_gnt    = 1'b0;
            cpu_port_o.data_rvalid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= PfIdle;
            cpu_cnt_q     <= '0;
            issued_q      <= '0;
            dropped_q     <= '0;
            issued_addr_q <= '0;
            issued_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_cnt_q <= cpu_cnt_d;
            if (pop) begin
                issued_addr_q <= head;
                issued_vld_q  <= 1'b1;
                if (issued_q != '1) issued_q <= issued_q + 32'd1;
            end
            if (pf_valid_i && !push && dropped_q != '1) begin
                dropped_q <= dropped_q + 32'd1;
            end
        end
    end

endmodule
